// File: rtl/videocard_pkg.sv
// Shared definitions for the videocard job loader: FSM states and control-port map.
package videocard_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_DATA  = 4'd1,
        ST_LOAD_PROG  = 4'd2,
        ST_CORE_EN    = 4'd3,
        ST_START      = 4'd4,
        ST_POLL_WAIT  = 4'd5,
        ST_POLL_READ  = 4'd6,
        ST_POLL_CHECK = 4'd7,
        ST_CLEAR      = 4'd8,
        ST_DONE       = 4'd9
    } loader_state_e;

    localparam logic [2:0] CTRL_START     = 3'd0;
    localparam logic [2:0] CTRL_STATUS    = 3'd1;
    localparam logic [2:0] CTRL_CORE_BASE = 3'd2;

    localparam int PROG_BASE_DEFAULT = 65536;

endpackage

// File: rtl/videocard_job_loader.sv
// Host-side sequencer: streams one job into the videocard memory, starts the cores,
// polls the finish status, clears it and reports done (or timeout).
module videocard_job_loader
    import videocard_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 17,
    parameter int PROG_BASE  = PROG_BASE_DEFAULT,
    parameter int NUM_CORES  = 4,
    parameter int CNT_W      = 16,
    parameter int POLL_GAP   = 16,
    parameter int POLL_LIMIT = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 job_start,
    input  logic [CNT_W-1:0]     job_data_cnt,
    input  logic [CNT_W-1:0]     job_prog_cnt,
    input  logic [NUM_CORES-1:0] job_core_mask,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic [ADDR_W-1:0]    address,
    output logic [WIDTH-1:0]     data_in,
    output logic                 write,
    output logic [2:0]           address_control,
    output logic [WIDTH-1:0]     data_in_control,
    output logic                 write_control,
    output logic                 read_control,
    input  logic [WIDTH-1:0]     data_out_control,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int GAP_W  = $clog2(POLL_GAP + 1);
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    localparam logic [ADDR_W-1:0] PROG_BASE_ADDR = ADDR_W'(PROG_BASE);

    loader_state_e        state_r;
    logic [CNT_W-1:0]     idx_r;
    logic [CNT_W-1:0]     data_cnt_r;
    logic [CNT_W-1:0]     prog_cnt_r;
    logic [NUM_CORES-1:0] mask_r;
    logic [CORE_W-1:0]    core_idx_r;
    logic [GAP_W-1:0]     gap_r;
    logic [POLL_W-1:0]    poll_r;

    // Loader FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            idx_r           <= {CNT_W{1'b0}};
            data_cnt_r      <= {CNT_W{1'b0}};
            prog_cnt_r      <= {CNT_W{1'b0}};
            mask_r          <= {NUM_CORES{1'b0}};
            core_idx_r      <= {CORE_W{1'b0}};
            gap_r           <= {GAP_W{1'b0}};
            poll_r          <= {POLL_W{1'b0}};
            s_ready         <= 1'b0;
            address         <= {ADDR_W{1'b0}};
            data_in         <= {WIDTH{1'b0}};
            write           <= 1'b0;
            address_control <= 3'd0;
            data_in_control <= {WIDTH{1'b0}};
            write_control   <= 1'b0;
            read_control    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            write         <= 1'b0;
            write_control <= 1'b0;
            read_control  <= 1'b0;
            done          <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (job_start) begin
                        data_cnt_r <= job_data_cnt;
                        prog_cnt_r <= job_prog_cnt;
                        mask_r     <= job_core_mask;
                        idx_r      <= {CNT_W{1'b0}};
                        core_idx_r <= {CORE_W{1'b0}};
                        busy       <= 1'b1;
                        timeout    <= 1'b0;
                        // Empty phases are skipped so s_ready never rises for them.
                        if (job_data_cnt != {CNT_W{1'b0}}) begin
                            state_r <= ST_LOAD_DATA;
                            s_ready <= 1'b1;
                        end else if (job_prog_cnt != {CNT_W{1'b0}}) begin
                            state_r <= ST_LOAD_PROG;
                            s_ready <= 1'b1;
                        end else begin
                            state_r <= ST_CORE_EN;
                        end
                    end
                end
                ST_LOAD_DATA: begin
                    if (s_valid && s_ready) begin
                        write   <= 1'b1;
                        address <= ADDR_W'(idx_r);
                        data_in <= s_data;
                        if (idx_r == data_cnt_r - CNT_W'(1)) begin
                            idx_r   <= {CNT_W{1'b0}};
                            s_ready <= 1'b0;
                            state_r <= (prog_cnt_r != {CNT_W{1'b0}}) ? ST_LOAD_PROG : ST_CORE_EN;
                        end else begin
                            idx_r <= idx_r + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_PROG: begin
                    if (s_valid && s_ready) begin
                        write   <= 1'b1;
                        address <= PROG_BASE_ADDR + ADDR_W'(idx_r);
                        data_in <= s_data;
                        if (idx_r == prog_cnt_r - CNT_W'(1)) begin
                            s_ready <= 1'b0;
                            state_r <= ST_CORE_EN;
                        end else begin
                            idx_r <= idx_r + CNT_W'(1);
                        end
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_CORE_EN: begin
                    write_control   <= 1'b1;
                    address_control <= CTRL_CORE_BASE + 3'(core_idx_r);
                    data_in_control <= WIDTH'(mask_r[core_idx_r]);
                    if (core_idx_r == CORE_W'(NUM_CORES - 1)) begin
                        state_r <= ST_START;
                    end else begin
                        core_idx_r <= core_idx_r + CORE_W'(1);
                    end
                end
                ST_START: begin
                    write_control   <= 1'b1;
                    address_control <= CTRL_START;
                    data_in_control <= WIDTH'(1);
                    gap_r           <= {GAP_W{1'b0}};
                    poll_r          <= {POLL_W{1'b0}};
                    state_r         <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    // Read is issued on leaving the gap so the data lands in POLL_CHECK.
                    if (gap_r == GAP_W'(POLL_GAP - 1)) begin
                        read_control    <= 1'b1;
                        address_control <= CTRL_STATUS;
                        state_r         <= ST_POLL_READ;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                ST_POLL_READ: begin
                    state_r <= ST_POLL_CHECK;
                end
                ST_POLL_CHECK: begin
                    gap_r <= {GAP_W{1'b0}};
                    if (data_out_control != {WIDTH{1'b0}}) begin
                        write_control   <= 1'b1;
                        address_control <= CTRL_STATUS;
                        data_in_control <= {WIDTH{1'b0}};
                        state_r         <= ST_CLEAR;
                    end else if (poll_r == POLL_W'(POLL_LIMIT - 1)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        poll_r  <= poll_r + POLL_W'(1);
                        state_r <= ST_POLL_WAIT;
                    end
                end
                ST_CLEAR: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_videocard_job_loader.sv
// Scoreboard bench for videocard_job_loader: expected memory/control writes are queued
// when a job is issued and compared as the loader emits them.
module tb_videocard_job_loader;

    localparam int WIDTH     = 32;
    localparam int ADDR_W    = 17;
    localparam int PROG_BASE = 65536;
    localparam int NUM_CORES = 4;
    localparam int CNT_W     = 16;
    localparam int POLL_GAP  = 16;
    localparam int STATUS_AT = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 job_start;
    logic [CNT_W-1:0]     job_data_cnt, job_prog_cnt;
    logic [NUM_CORES-1:0] job_core_mask;
    logic                 s_valid, s_ready;
    logic [WIDTH-1:0]     s_data;
    logic [ADDR_W-1:0]    address;
    logic [WIDTH-1:0]     data_in, data_in_control, data_out_control;
    logic                 write, write_control, read_control, busy, done, timeout;
    logic [2:0]           address_control;

    // second loader with a short poll limit for the timeout scenario
    logic                 job_start2, s_valid2, s_ready2, write2, write_control2, read_control2;
    logic                 busy2, done2, timeout2;
    logic [ADDR_W-1:0]    address2;
    logic [WIDTH-1:0]     data_in2, data_in_control2, s_data2, data_out_control2;
    logic [2:0]           address_control2;

    int total = 0;
    int bad   = 0;

    logic [48:0] wq[$];
    logic [34:0] cq[$];
    int wr_cnt = 0, low_wr = 0, done_cnt = 0;
    int card_reads = 0, card_base = 0;
    logic [WIDTH-1:0] status_r = '0;
    int cyc = 0;
    int reads2 = 0, last_rd2 = 0, clear2 = 0, ctrl2 = 0, done2_cnt = 0;

    videocard_job_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .PROG_BASE(PROG_BASE),
        .NUM_CORES(NUM_CORES), .CNT_W(CNT_W), .POLL_GAP(POLL_GAP), .POLL_LIMIT(65535)) dut (
        .clk(clk), .reset_n(reset_n), .job_start(job_start), .job_data_cnt(job_data_cnt),
        .job_prog_cnt(job_prog_cnt), .job_core_mask(job_core_mask), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .address(address), .data_in(data_in),
        .write(write), .address_control(address_control), .data_in_control(data_in_control),
        .write_control(write_control), .read_control(read_control),
        .data_out_control(data_out_control), .busy(busy), .done(done), .timeout(timeout));

    videocard_job_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .PROG_BASE(PROG_BASE),
        .NUM_CORES(NUM_CORES), .CNT_W(CNT_W), .POLL_GAP(POLL_GAP), .POLL_LIMIT(8)) dut_to (
        .clk(clk), .reset_n(reset_n), .job_start(job_start2), .job_data_cnt(16'd0),
        .job_prog_cnt(16'd0), .job_core_mask(4'b1010), .s_valid(s_valid2),
        .s_ready(s_ready2), .s_data(s_data2), .address(address2), .data_in(data_in2),
        .write(write2), .address_control(address_control2), .data_in_control(data_in_control2),
        .write_control(write_control2), .read_control(read_control2),
        .data_out_control(data_out_control2), .busy(busy2), .done(done2), .timeout(timeout2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dval(input int i);
        case (i)
            0:       return 32'd9;
            1:       return 32'd3;
            2:       return 32'd4;
            default: return 32'(i - 3);
        endcase
    endfunction

    function automatic logic [31:0] pval(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // status register model: set on the STATUS_AT-th read since the job began
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read_control) begin
            card_reads <= card_reads + 1;
            status_r   <= (card_reads + 1 - card_base >= STATUS_AT) ? 32'd1 : 32'd0;
        end
    end
    assign data_out_control = status_r;

    // scoreboard and strobe monitor for the main loader
    always @(negedge clk) begin
        int n;
        logic [48:0] ew;
        logic [34:0] ec;
        n = int'(write) + int'(write_control) + int'(read_control);
        if (n != 0) check("one_strobe", 64'(n), 64'd1);
        if (write) begin
            wr_cnt++;
            if (address < ADDR_W'(PROG_BASE)) low_wr++;
            check("wr_pending", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                ew = wq.pop_front();
                check("wr_addr", 64'(address), 64'(ew[48:32]));
                check("wr_data", 64'(data_in), 64'(ew[31:0]));
            end
        end
        if (write_control) begin
            check("ctl_pending", 64'(cq.size() != 0), 64'd1);
            if (cq.size() != 0) begin
                ec = cq.pop_front();
                check("ctl_addr", 64'(address_control), 64'(ec[34:32]));
                check("ctl_data", 64'(data_in_control), 64'(ec[31:0]));
            end
        end
        if (done) done_cnt++;
    end

    // monitor for the timeout loader
    always @(negedge clk) begin
        if (read_control2) begin
            if (reads2 > 0) check("poll_spacing", 64'(cyc - last_rd2), 64'(POLL_GAP + 2));
            last_rd2 = cyc;
            reads2++;
        end
        if (write_control2) begin
            ctrl2++;
            if (address_control2 == 3'd1) clear2++;
        end
        if (done2) done2_cnt++;
    end

    task automatic send_word(input logic [31:0] w, input bit gaps);
        bit ok;
        logic rdy;
        if (gaps) begin
            while ($urandom_range(1, 0) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = w;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
        end
        #1;
        s_valid = 1'b0;
        if (!ok) check("stream_accept", 64'd0, 64'd1);
    endtask

    task automatic issue_job(input int dcnt, input int pcnt, input logic [3:0] mask);
        for (int i = 0; i < dcnt; i++) wq.push_back({17'(i), dval(i)});
        for (int i = 0; i < pcnt; i++) wq.push_back({17'(PROG_BASE + i), pval(i)});
        for (int i = 0; i < NUM_CORES; i++) cq.push_back({3'(2 + i), 31'd0, mask[i]});
        cq.push_back({3'd0, 32'd1});
        cq.push_back({3'd1, 32'd0});
        card_base     = card_reads;
        job_data_cnt  = 16'(dcnt);
        job_prog_cnt  = 16'(pcnt);
        job_core_mask = mask;
        job_start     = 1'b1;
        @(posedge clk); #1;
        job_start     = 1'b0;
    endtask

    task automatic run_job(input int dcnt, input int pcnt, input logic [3:0] mask,
                           input bit gaps, input bit poke);
        int d0, w0, l0;
        bit seen;
        d0 = done_cnt;
        l0 = low_wr;
        issue_job(dcnt, pcnt, mask);
        for (int i = 0; i < dcnt; i++) send_word(dval(i), gaps);
        for (int i = 0; i < pcnt; i++) send_word(pval(i), gaps);
        if (poke) begin
            repeat (60) @(negedge clk);
            check("busy_polling", 64'(busy), 64'd1);
            w0 = wr_cnt;
            job_data_cnt  = 16'd5;
            job_prog_cnt  = 16'd5;
            job_core_mask = 4'b1111;
            job_start     = 1'b1;
            @(posedge clk); #1;
            job_start     = 1'b0;
            repeat (3) @(negedge clk);
            check("poke_no_ready", 64'(s_ready), 64'd0);
            check("poke_no_write", 64'(wr_cnt - w0), 64'd0);
        end
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        repeat (4) @(negedge clk);
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("polls", 64'(card_reads - card_base), 64'(STATUS_AT));
        check("wq_left", 64'(wq.size()), 64'd0);
        check("cq_left", 64'(cq.size()), 64'd0);
        if (dcnt == 0) check("no_low_writes", 64'(low_wr - l0), 64'd0);
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; job_start = 1'b0; job_start2 = 1'b0;
        job_data_cnt = '0; job_prog_cnt = '0; job_core_mask = '0;
        s_valid = 1'b0; s_data = '0; s_valid2 = 1'b0; s_data2 = '0;
        data_out_control2 = '0;
        repeat (3) @(negedge clk);
        check("rst_mem", 64'({address, data_in, write, s_ready}), 64'd0);
        check("rst_ctl", 64'({address_control, data_in_control, write_control, read_control,
                              busy, done, timeout}), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_job(20, 125, 4'b0111, 1'b0, 1'b0);
        run_job(20, 125, 4'b0111, 1'b1, 1'b0);
        run_job(0, 3, 4'b0111, 1'b0, 1'b0);
        run_job(20, 125, 4'b0111, 1'b0, 1'b1);

        // abort mid program load, then rerun the same job
        issue_job(20, 125, 4'b0111);
        for (int i = 0; i < 20; i++) send_word(dval(i), 1'b0);
        for (int i = 0; i < 40; i++) send_word(pval(i), 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_mem", 64'({address, data_in, write, s_ready}), 64'd0);
        check("abort_ctl", 64'({address_control, data_in_control, write_control, read_control,
                                busy, done, timeout}), 64'd0);
        wq.delete();
        cq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_job(20, 125, 4'b0111, 1'b0, 1'b0);

        // poll timeout on the short-limit instance
        job_start2 = 1'b1;
        @(posedge clk); #1;
        job_start2 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (timeout2) seen = 1'b1;
        end
        check("timeout_seen", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        check("timeout_reads", 64'(reads2), 64'd8);
        check("timeout_sticky", 64'(timeout2), 64'd1);
        check("timeout_busy", 64'(busy2), 64'd0);
        check("timeout_no_done", 64'(done2_cnt), 64'd0);
        check("timeout_no_clear", 64'(clear2), 64'd0);
        check("timeout_ctl_writes", 64'(ctrl2), 64'(NUM_CORES + 1));
        job_start2 = 1'b1;
        @(posedge clk); #1;
        job_start2 = 1'b0;
        @(negedge clk);
        check("timeout_cleared", 64'(timeout2), 64'd0);
        check("restart_busy", 64'(busy2), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
